// File: rtl/uart_pkg.sv
// Shared constants for the UART register-access link: command bytes,
// response codes and the responder state encoding.
package uart_pkg;

  localparam logic [7:0] CMD_WR_DEF = 8'h57;
  localparam logic [7:0] CMD_RD_DEF = 8'h52;
  localparam logic [7:0] RESP_ACK   = 8'h06;
  localparam logic [7:0] RESP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_SEND,
    ST_WAIT_ACC
  } state_t;

endpackage

// File: rtl/uart_reg_responder.sv
// Byte-stream command responder: parses W/R frames from uart_rx, accesses an
// internal register file and hands one response byte to uart_tx per frame.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int         NUM_REGS       = 16,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] CMD_WR         = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD         = CMD_RD_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_busy,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_timeout,
  output logic                  o_overrun
);

  localparam int               TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int               IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       NUM_REGS_9 = 9'(NUM_REGS);

  state_t           state;
  logic             cmd_is_wr;
  logic [7:0]       addr;
  logic [TMR_W-1:0] timer;
  logic [7:0]       regs [NUM_REGS];

  // Full 8-bit compare so addresses above the register count never alias.
  function automatic logic addr_ok(input logic [7:0] a);
    return {1'b0, a} < NUM_REGS_9;
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [7:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [7:0] read_resp(input logic [7:0] a,
                                           input logic [7:0] rd_val);
    return addr_ok(a) ? rd_val : RESP_NAK;
  endfunction

  logic       timer_done;
  logic [7:0] rd_rx_addr;

  assign timer_done = (timer == TMR_LAST);
  assign rd_rx_addr = regs[to_idx(i_rx_data)];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[8*k +: 8] = regs[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cmd_is_wr  <= 1'b0;
      addr       <= 8'h00;
      timer      <= '0;
      o_tx_data  <= 8'h00;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= 8'h00;
      end
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (i_rx_valid) begin
            if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
              cmd_is_wr <= (i_rx_data == CMD_WR);
              state     <= ST_GET_ADDR;
            end else begin
              o_tx_data <= RESP_NAK;
              state     <= ST_SEND;
            end
          end
        end

        ST_GET_ADDR: begin
          if (i_rx_valid) begin
            addr  <= i_rx_data;
            timer <= '0;
            if (cmd_is_wr) begin
              state <= ST_GET_DATA;
            end else begin
              o_tx_data <= read_resp(i_rx_data, rd_rx_addr);
              state     <= ST_SEND;
            end
          end else if (timer_done) begin
            timer     <= '0;
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        ST_GET_DATA: begin
          if (i_rx_valid) begin
            timer <= '0;
            if (addr_ok(addr)) begin
              regs[to_idx(addr)] <= i_rx_data;
              o_tx_data          <= RESP_ACK;
            end else begin
              o_tx_data <= RESP_NAK;
            end
            state <= ST_SEND;
          end else if (timer_done) begin
            timer     <= '0;
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        // Response byte is already stable; only the start strobe is gated.
        ST_SEND: begin
          timer <= '0;
          if (i_rx_valid) begin
            o_overrun <= 1'b1;
          end
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            state      <= ST_WAIT_ACC;
          end
        end

        // Leave as soon as uart_tx shows busy; completion is not awaited.
        ST_WAIT_ACC: begin
          if (i_rx_valid) begin
            o_overrun <= 1'b1;
          end
          if (i_tx_busy) begin
            timer <= '0;
            state <= ST_IDLE;
          end else if (i_rx_valid) begin
            timer <= '0;
          end else if (timer_done) begin
            timer     <= '0;
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          timer <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with a simple uart_tx busy model.
module tb_uart_reg_responder;
  import uart_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int TO       = 100;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  tx_busy = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic [NUM_REGS*8-1:0] regs;
  logic                  timeout;
  logic                  overrun;

  uart_reg_responder #(
    .NUM_REGS       (NUM_REGS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_busy  (tx_busy),
    .o_regs     (regs),
    .o_timeout  (timeout),
    .o_overrun  (overrun)
  );

  initial forever #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         start_cnt = 0;
  int         to_cnt    = 0;
  int         ov_cnt    = 0;
  int         busy_cnt  = 0;
  bit         force_busy = 1'b0;
  logic [7:0] resp_q[$];
  logic [NUM_REGS*8-1:0] exp_regs = '0;

  // Output monitor plus uart_tx model: busy for 4 cycles after each start.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      start_cnt++;
      resp_q.push_back(tx_data);
      busy_cnt = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (timeout) to_cnt++;
    if (overrun) ov_cnt++;
    tx_busy = force_busy || (busy_cnt > 0);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    check(tag, tx_busy, 1'b0);
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 50 && resp_q.size() == 0; i++) @(negedge clk);
    if (resp_q.size() == 0) check({tag, "_none"}, 9'h100, exp);
    else                    check(tag, resp_q.pop_front(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, t0, o0;

    repeat (3) @(negedge clk);
    check("rst_regs", regs, '0);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_start", tx_start, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write then read back, including start latency of two cycles.
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    expect_resp("wr03_ack", RESP_ACK);
    exp_regs[31:24] = 8'hA5;
    check("wr03_regs", regs, exp_regs);
    wait_tx_idle("idle1");
    send_byte(8'h52); send_byte(8'h03);
    @(negedge clk);
    check("rd03_latency", tx_start, 1'b1);
    check("rd03_data", tx_data, 8'hA5);
    expect_resp("rd03_resp", 8'hA5);

    // Highest legal address.
    wait_tx_idle("idle2");
    send_byte(8'h57); send_byte(8'h0F); send_byte(8'h3C);
    expect_resp("wr0f_ack", RESP_ACK);
    exp_regs[127:120] = 8'h3C;
    check("wr0f_regs", regs, exp_regs);
    wait_tx_idle("idle3");
    send_byte(8'h52); send_byte(8'h0F);
    expect_resp("rd0f_resp", 8'h3C);

    // Unknown command.
    wait_tx_idle("idle4");
    send_byte(8'h41);
    expect_resp("badcmd_nak", RESP_NAK);
    check("badcmd_regs", regs, exp_regs);
    wait_tx_idle("idle5");
    send_byte(8'h52); send_byte(8'h00);
    expect_resp("rd00_resp", 8'h00);

    // Out-of-range addresses.
    wait_tx_idle("idle6");
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hFF);
    expect_resp("wr10_nak", RESP_NAK);
    check("wr10_regs", regs, exp_regs);
    wait_tx_idle("idle7");
    send_byte(8'h52); send_byte(8'h20);
    expect_resp("rd20_nak", RESP_NAK);

    // Inter-byte timeout.
    wait_tx_idle("idle8");
    t0 = to_cnt; s0 = start_cnt;
    send_byte(8'h57); send_byte(8'h05);
    repeat (95) @(negedge clk);
    check("to_early", to_cnt - t0, 0);
    repeat (15) @(negedge clk);
    check("to_pulse", to_cnt - t0, 1);
    check("to_nostart", start_cnt - s0, 0);
    check("to_regs", regs, exp_regs);
    send_byte(8'h52); send_byte(8'h05);
    expect_resp("rd05_resp", 8'h00);

    // Backpressure and overrun.
    wait_tx_idle("idle9");
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    s0 = start_cnt; o0 = ov_cnt;
    send_byte(8'h52); send_byte(8'h00);
    repeat (5) @(negedge clk);
    check("bp_nostart", start_cnt - s0, 0);
    send_byte(8'h33);
    @(negedge clk);
    check("bp_overrun", ov_cnt - o0, 1);
    check("bp_nostart2", start_cnt - s0, 0);
    force_busy = 1'b0;
    expect_resp("bp_resp", 8'h00);
    repeat (10) @(negedge clk);
    check("bp_one_start", start_cnt - s0, 1);

    // Reset in the middle of a write frame.
    wait_tx_idle("idle10");
    send_byte(8'h57); send_byte(8'h02);
    @(negedge clk);
    rx_data = 8'hAA; rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_regs", regs, '0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_regs = '0;
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    check("mid_rst_nostart", start_cnt - s0, 0);
    send_byte(8'h52); send_byte(8'h02);
    expect_resp("rd02_resp", 8'h00);
    check("mid_rst_regs2", regs, exp_regs);

    repeat (10) @(negedge clk);
    check("no_extra_resp", resp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
